// File: rtl/axi_ram_slave.sv
// AXI3 slave backed by a single-ported 32-bit RAM, one transaction in flight.
// R beats start the cycle after AR and stall on rready; B is raised the cycle after the wlast beat.
module axi_ram_slave #(
  parameter int ADDR_W = 12
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  arid,
  input  logic [31:0] araddr,
  input  logic [3:0]  arlen,
  input  logic [2:0]  arsize,
  input  logic [1:0]  arburst,
  input  logic [1:0]  arlock,
  input  logic [3:0]  arcache,
  input  logic [2:0]  arprot,
  input  logic        arvalid,
  output logic        arready,
  output logic [3:0]  rid,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rlast,
  output logic        rvalid,
  input  logic        rready,
  input  logic [3:0]  awid,
  input  logic [31:0] awaddr,
  input  logic [3:0]  awlen,
  input  logic [2:0]  awsize,
  input  logic [1:0]  awburst,
  input  logic [1:0]  awlock,
  input  logic [3:0]  awcache,
  input  logic [2:0]  awprot,
  input  logic        awvalid,
  output logic        awready,
  input  logic [3:0]  wid,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wlast,
  input  logic        wvalid,
  output logic        wready,
  output logic [3:0]  bid,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready
);

  typedef enum logic [1:0] {IDLE, RD, WR, WRESP} state_t;

  localparam logic [ADDR_W-1:0] IDX_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_t            state, state_nxt;
  logic [31:0]       mem [2**ADDR_W];
  logic              last_grant_wr;
  logic [ADDR_W-1:0] ar_idx, aw_idx, rd_idx, rd_idx_nxt, wr_idx;
  logic [3:0]        rd_len, rd_beat, wr_len, wr_beat;
  logic              rd_fixed, wr_fixed, wr_size_ok;
  logic              ar_hs, aw_hs, r_hs, w_hs;
  logic              unused_ok;

  assign ar_idx     = araddr[ADDR_W+1:2];
  assign aw_idx     = awaddr[ADDR_W+1:2];
  assign rd_idx_nxt = rd_fixed ? rd_idx : rd_idx + IDX_ONE;

  assign rvalid = (state == RD);
  assign rlast  = rvalid && (rd_beat == rd_len);
  assign bvalid = (state == WRESP);

  assign ar_hs = arvalid && arready;
  assign aw_hs = awvalid && awready;
  assign r_hs  = rvalid && rready;
  assign w_hs  = wvalid && wready;

  assign unused_ok = ^{arlock, arcache, arprot, awlock, awcache, awprot, wid,
                       araddr[31:ADDR_W+2], araddr[1:0], awaddr[31:ADDR_W+2], awaddr[1:0]};

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // On a tie the class that did not win last time gets the slot.
  always_comb begin
    state_nxt = state;
    arready   = 1'b0;
    awready   = 1'b0;
    wready    = 1'b0;
    case (state)
      IDLE: begin
        if (arvalid && (!awvalid || last_grant_wr)) begin
          arready   = 1'b1;
          state_nxt = RD;
        end else if (awvalid) begin
          awready   = 1'b1;
          state_nxt = WR;
        end
      end
      RD:      if (rvalid && rready && rlast) state_nxt = IDLE;
      WR: begin
        wready = 1'b1;
        if (wvalid && wlast) state_nxt = WRESP;
      end
      WRESP:   if (bready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_wr <= 1'b1;
      rd_beat       <= '0;
      wr_beat       <= '0;
      rd_len        <= '0;
      wr_len        <= '0;
      rd_idx        <= '0;
      wr_idx        <= '0;
      rd_fixed      <= 1'b0;
      wr_fixed      <= 1'b0;
      wr_size_ok    <= 1'b0;
      rid           <= '0;
      bid           <= '0;
      rresp         <= '0;
      bresp         <= '0;
      rdata         <= '0;
    end else begin
      if (ar_hs) begin
        last_grant_wr <= 1'b0;
        rid           <= arid;
        rd_len        <= arlen;
        rd_fixed      <= (arburst == 2'b00);
        rd_beat       <= '0;
        rd_idx        <= ar_idx;
        rresp         <= (arsize == 3'b010) ? 2'b00 : 2'b10;
        rdata         <= (arsize == 3'b010) ? mem[ar_idx] : '0;
      end else if (r_hs && !rlast) begin
        rd_beat <= rd_beat + 4'd1;
        rd_idx  <= rd_idx_nxt;
        rdata   <= (rresp == 2'b00) ? mem[rd_idx_nxt] : '0;
      end

      if (aw_hs) begin
        last_grant_wr <= 1'b1;
        bid           <= awid;
        wr_len        <= awlen;
        wr_fixed      <= (awburst == 2'b00);
        wr_size_ok    <= (awsize == 3'b010);
        wr_beat       <= '0;
        wr_idx        <= aw_idx;
      end else if (w_hs) begin
        wr_beat <= wr_beat + 4'd1;
        if (!wr_fixed) wr_idx <= wr_idx + IDX_ONE;
        if (wlast) bresp <= (!wr_size_ok || wr_beat != wr_len) ? 2'b10 : 2'b00;
      end
    end
  end

  // Array is deliberately left out of reset; writes land on the beat edge so B always sees them.
  always_ff @(posedge clk) begin
    if (!rst && w_hs && wr_size_ok) begin
      for (int k = 0; k < 4; k++) begin
        if (wstrb[k]) mem[wr_idx][8*k +: 8] <= wdata[8*k +: 8];
      end
    end
  end

endmodule

// File: tb/tb_axi_ram_slave.sv
// Bench for axi_ram_slave: table vectors, hand-written corner sequences, random traffic vs a word-array model.
module tb_axi_ram_slave;
  localparam int AW    = 12;
  localparam int DEPTH = 1 << AW;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  arid = '0, awid = '0, wid = '0;
  logic [31:0] araddr = '0, awaddr = '0, wdata = '0;
  logic [3:0]  arlen = '0, awlen = '0, wstrb = '0;
  logic [2:0]  arsize = '0, awsize = '0;
  logic [1:0]  arburst = '0, awburst = '0;
  logic [1:0]  arlock = 2'b01, awlock = 2'b10;
  logic [3:0]  arcache = 4'hF, awcache = 4'h3;
  logic [2:0]  arprot = 3'b101, awprot = 3'b010;
  logic        arvalid = 1'b0, awvalid = 1'b0, wvalid = 1'b0, wlast = 1'b0;
  logic        rready = 1'b0, bready = 1'b0;
  logic        arready, awready, wready, rvalid, rlast, bvalid;
  logic [3:0]  rid, bid;
  logic [31:0] rdata;
  logic [1:0]  rresp, bresp;

  always #5 clk = ~clk;

  axi_ram_slave #(.ADDR_W(AW)) dut (
    .clk(clk), .rst(rst),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] model [DEPTH];
  bit          known [DEPTH];
  logic [31:0] wbuf [16];
  logic [3:0]  sbuf [16];
  logic [31:0] got_dat [16];
  logic [1:0]  got_resp [16];
  logic        got_last [16];
  logic [3:0]  got_id [16];
  int          got_n;

  typedef struct {
    bit          wr;
    logic [3:0]  id;
    logic [31:0] addr;
    logic [3:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic [31:0] d0;
    logic [31:0] dstep;
    logic [3:0]  strb;
    int          nbeats;
    logic [1:0]  exp_resp;
    logic [31:0] exp_d0;
    logic [31:0] exp_step;
  } vec_t;

  vec_t tbl [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%h, want 0x%h", name, act, exp);
    end
  endtask

  // Word touched by beat b: start word plus b for incrementing bursts, modulo the depth.
  function automatic int widx(input logic [31:0] addr, input int beat, input logic [1:0] burst);
    return (int'(addr[AW+1:2]) + ((burst == 2'b00) ? 0 : beat)) % DEPTH;
  endfunction

  function automatic logic [1:0] model_write(input logic [31:0] addr, input logic [3:0] len,
                                             input logic [2:0] size, input logic [1:0] burst,
                                             input int nbeats);
    int idx;
    for (int b = 0; b < nbeats; b++) begin
      if (size == 3'b010) begin
        idx = widx(addr, b, burst);
        for (int k = 0; k < 4; k++)
          if (sbuf[b][k]) model[idx][8*k +: 8] = wbuf[b][8*k +: 8];
        if (sbuf[b] == 4'hF) known[idx] = 1'b1;
      end
    end
    return (size != 3'b010 || nbeats - 1 != int'(len)) ? 2'b10 : 2'b00;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0; rready = 1'b0; bready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_ctrl", 32'({arready, awready, wready, rvalid, rlast, bvalid, rid, bid, rresp, bresp}), 32'h0);
    chk("rst_rdata", rdata, 32'h0);
    rst = 1'b0;
  endtask

  task automatic axi_write(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                           input logic [2:0] size, input logic [1:0] burst, input int nbeats,
                           input int bstall, output logic [1:0] resp, output logic [3:0] rbid);
    int t;
    resp = 2'bxx; rbid = 4'bxxxx;
    @(negedge clk);
    awid = id; awaddr = addr; awlen = len; awsize = size; awburst = burst; awvalid = 1'b1;
    #1; t = 0;
    while (!awready && t < 50) begin @(negedge clk); #1; t++; end
    if (!awready) begin chk("aw_timeout", 32'h0, 32'h1); awvalid = 1'b0; return; end
    @(negedge clk);
    awvalid = 1'b0;
    for (int b = 0; b < nbeats; b++) begin
      wvalid = 1'b1; wdata = wbuf[b]; wstrb = sbuf[b]; wlast = (b == nbeats - 1); wid = 4'(b);
      #1;
      chk("wready", 32'(wready), 32'h1);
      @(negedge clk);
    end
    wvalid = 1'b0; wlast = 1'b0; bready = 1'b0;
    #1;
    chk("b_latency", 32'(bvalid), 32'h1);
    resp = bresp; rbid = bid;
    for (int s = 0; s < bstall; s++) begin
      @(negedge clk); #1;
      chk("b_hold", 32'({bvalid, bresp, bid}), 32'({1'b1, resp, rbid}));
    end
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
    #1;
    chk("b_done", 32'(bvalid), 32'h0);
  endtask

  // mode 0: rready always high, 1: toggling starting low, 2: random.
  task automatic axi_read(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                          input logic [2:0] size, input logic [1:0] burst, input int mode);
    int t; bit done; logic pv, pr, pl; logic [31:0] pd; logic [1:0] prs; logic [3:0] pid;
    got_n = 0; done = 1'b0; pv = 1'b0; pr = 1'b0; pl = 1'b0; pd = '0; prs = '0; pid = '0;
    @(negedge clk);
    arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst; arvalid = 1'b1;
    #1; t = 0;
    while (!arready && t < 50) begin @(negedge clk); #1; t++; end
    if (!arready) begin chk("ar_timeout", 32'h0, 32'h1); arvalid = 1'b0; return; end
    @(negedge clk);
    arvalid = 1'b0;
    #1;
    chk("r_first_lat", 32'(rvalid), 32'h1);
    for (int i = 0; i < 200 && !done; i++) begin
      if (i > 0) begin @(negedge clk); #1; end
      if (pv && !pr) begin
        chk("r_stall_data", rdata, pd);
        chk("r_stall_ctrl", 32'({rvalid, rlast, rresp, rid}), 32'({pv, pl, prs, pid}));
      end
      if (mode == 0) begin
        rready = 1'b1;
        chk("r_no_bubble", 32'(rvalid), 32'h1);
      end else if (mode == 1) rready = ((i % 2) == 1);
      else rready = 1'($urandom_range(0, 1));
      pv = rvalid; pr = rready; pd = rdata; prs = rresp; pl = rlast; pid = rid;
      if (rvalid && rready) begin
        if (got_n < 16) begin
          got_dat[got_n] = rdata; got_resp[got_n] = rresp;
          got_last[got_n] = rlast; got_id[got_n] = rid;
        end
        got_n++;
        if (rlast || got_n > 16) done = 1'b1;
      end
    end
    if (!done) chk("r_timeout", 32'h0, 32'h1);
    @(negedge clk);
    rready = 1'b0;
    #1;
    chk("r_done", 32'(rvalid), 32'h0);
  endtask

  task automatic check_read_model(input string tag, input logic [3:0] id, input logic [31:0] addr,
                                  input logic [3:0] len, input logic [2:0] size, input logic [1:0] burst);
    int idx;
    chk({tag, "_nbeats"}, 32'(got_n), 32'(int'(len) + 1));
    for (int b = 0; b <= int'(len) && b < got_n && b < 16; b++) begin
      idx = widx(addr, b, burst);
      if (size != 3'b010) chk({tag, "_data"}, got_dat[b], 32'h0);
      else if (known[idx]) chk({tag, "_data"}, got_dat[b], model[idx]);
      chk({tag, "_resp"}, 32'(got_resp[b]), (size == 3'b010) ? 32'h0 : 32'h2);
      chk({tag, "_last"}, 32'(got_last[b]), 32'(b == int'(len)));
      chk({tag, "_rid"}, 32'(got_id[b]), 32'(id));
    end
  endtask

  task automatic run_table();
    vec_t v; logic [1:0] resp; logic [3:0] rb;
    //          wr    id    addr          len   size    burst  d0            dstep  strb     n  resp   exp_d0        exp_step
    tbl.push_back('{1'b1, 4'h3, 32'h0000_0010, 4'd0, 3'b010, 2'b01, 32'hDEADBEEF, 32'd0, 4'hF,    1, 2'b00, 32'h0,        32'd0});
    tbl.push_back('{1'b0, 4'h3, 32'h0000_0010, 4'd0, 3'b010, 2'b01, 32'h0,        32'd0, 4'h0,    0, 2'b00, 32'hDEADBEEF, 32'd0});
    tbl.push_back('{1'b1, 4'h5, 32'h0000_0100, 4'd3, 3'b010, 2'b01, 32'h1,        32'd1, 4'hF,    4, 2'b00, 32'h0,        32'd0});
    tbl.push_back('{1'b0, 4'h5, 32'h0000_0100, 4'd3, 3'b010, 2'b01, 32'h0,        32'd0, 4'h0,    0, 2'b00, 32'h1,        32'd1});
    tbl.push_back('{1'b1, 4'h1, 32'h0000_0200, 4'd0, 3'b010, 2'b01, 32'h11223344, 32'd0, 4'hF,    1, 2'b00, 32'h0,        32'd0});
    tbl.push_back('{1'b1, 4'h1, 32'h0000_0200, 4'd0, 3'b010, 2'b01, 32'h0000AA00, 32'd0, 4'b0010, 1, 2'b00, 32'h0,        32'd0});
    tbl.push_back('{1'b0, 4'h1, 32'h0000_0200, 4'd0, 3'b010, 2'b01, 32'h0,        32'd0, 4'h0,    0, 2'b00, 32'h1122AA44, 32'd0});
    tbl.push_back('{1'b0, 4'h2, 32'h0000_0100, 4'd1, 3'b001, 2'b01, 32'h0,        32'd0, 4'h0,    0, 2'b10, 32'h0,        32'd0});
    tbl.push_back('{1'b1, 4'h6, 32'h0000_0300, 4'd2, 3'b010, 2'b01, 32'hA0,       32'd1, 4'hF,    2, 2'b10, 32'h0,        32'd0});
    tbl.push_back('{1'b1, 4'h7, 32'h0000_0100, 4'd0, 3'b000, 2'b01, 32'hFFFFFFFF, 32'd0, 4'hF,    1, 2'b10, 32'h0,        32'd0});
    tbl.push_back('{1'b0, 4'h7, 32'h0000_0100, 4'd0, 3'b010, 2'b01, 32'h0,        32'd0, 4'h0,    0, 2'b00, 32'h1,        32'd0});
    tbl.push_back('{1'b1, 4'h8, 32'h0000_0400, 4'd2, 3'b010, 2'b00, 32'h7,        32'd1, 4'hF,    3, 2'b00, 32'h0,        32'd0});
    tbl.push_back('{1'b0, 4'h8, 32'h0000_0400, 4'd0, 3'b010, 2'b01, 32'h0,        32'd0, 4'h0,    0, 2'b00, 32'h9,        32'd0});
    tbl.push_back('{1'b1, 4'h9, 32'h0000_3FFC, 4'd1, 3'b010, 2'b01, 32'hC0,       32'd1, 4'hF,    2, 2'b00, 32'h0,        32'd0});
    tbl.push_back('{1'b0, 4'h9, 32'h0000_3FFC, 4'd1, 3'b010, 2'b01, 32'h0,        32'd0, 4'h0,    0, 2'b00, 32'hC0,       32'd1});
    tbl.push_back('{1'b0, 4'h9, 32'h0000_0000, 4'd0, 3'b010, 2'b01, 32'h0,        32'd0, 4'h0,    0, 2'b00, 32'hC1,       32'd0});
    tbl.push_back('{1'b0, 4'hA, 32'hFFFF_4013, 4'd0, 3'b010, 2'b01, 32'h0,        32'd0, 4'h0,    0, 2'b00, 32'hDEADBEEF, 32'd0});
    tbl.push_back('{1'b0, 4'hB, 32'h0000_0100, 4'd2, 3'b010, 2'b00, 32'h0,        32'd0, 4'h0,    0, 2'b00, 32'h1,        32'd0});
    tbl.push_back('{1'b1, 4'hC, 32'h0000_0500, 4'd1, 3'b010, 2'b11, 32'h55,       32'd1, 4'hF,    2, 2'b00, 32'h0,        32'd0});
    tbl.push_back('{1'b0, 4'hC, 32'h0000_0504, 4'd0, 3'b010, 2'b01, 32'h0,        32'd0, 4'h0,    0, 2'b00, 32'h56,       32'd0});
    for (int i = 0; i < tbl.size(); i++) begin
      v = tbl[i];
      if (v.wr) begin
        for (int b = 0; b < 16; b++) begin
          wbuf[b] = v.d0 + 32'(b) * v.dstep;
          sbuf[b] = v.strb;
        end
        axi_write(v.id, v.addr, v.len, v.size, v.burst, v.nbeats, i % 3, resp, rb);
        void'(model_write(v.addr, v.len, v.size, v.burst, v.nbeats));
        chk($sformatf("v%0d_bresp", i), 32'(resp), 32'(v.exp_resp));
        chk($sformatf("v%0d_bid", i), 32'(rb), 32'(v.id));
      end else begin
        axi_read(v.id, v.addr, v.len, v.size, v.burst, 0);
        chk($sformatf("v%0d_nbeats", i), 32'(got_n), 32'(int'(v.len) + 1));
        for (int b = 0; b <= int'(v.len) && b < got_n && b < 16; b++) begin
          chk($sformatf("v%0d_b%0d_data", i, b), got_dat[b], v.exp_d0 + 32'(b) * v.exp_step);
          chk($sformatf("v%0d_b%0d_resp", i, b), 32'(got_resp[b]), 32'(v.exp_resp));
          chk($sformatf("v%0d_b%0d_last", i, b), 32'(got_last[b]), 32'(b == int'(v.len)));
          chk($sformatf("v%0d_b%0d_rid", i, b), 32'(got_id[b]), 32'(v.id));
        end
      end
    end
  endtask

  task automatic run_tie_and_stall();
    do_reset();
    @(negedge clk);
    arid = 4'h1; araddr = 32'h10; arlen = 4'd0; arsize = 3'b010; arburst = 2'b01;
    awid = 4'h2; awaddr = 32'h20; awlen = 4'd0; awsize = 3'b010; awburst = 2'b01;
    arvalid = 1'b1; awvalid = 1'b1;
    #1;
    chk("tie1_arready", 32'(arready), 32'h1);
    chk("tie1_awready", 32'(awready), 32'h0);
    @(negedge clk);
    arvalid = 1'b0;
    #1;
    chk("tie1_awblocked", 32'(awready), 32'h0);
    chk("tie1_rvalid", 32'(rvalid), 32'h1);
    chk("tie1_rdata", rdata, 32'hDEADBEEF);
    rready = 1'b1;
    @(negedge clk);
    rready = 1'b0; arvalid = 1'b1;
    #1;
    chk("tie2_awready", 32'(awready), 32'h1);
    chk("tie2_arready", 32'(arready), 32'h0);
    @(negedge clk);
    arvalid = 1'b0; awvalid = 1'b0;
    wvalid = 1'b1; wdata = 32'h0BADF00D; wstrb = 4'hF; wlast = 1'b1;
    @(negedge clk);
    wvalid = 1'b0; wlast = 1'b0; bready = 1'b1;
    #1;
    chk("tie2_b", 32'({bvalid, bresp, bid}), 32'({1'b1, 2'b00, 4'h2}));
    @(negedge clk);
    bready = 1'b0;
    wbuf[0] = 32'h0BADF00D; sbuf[0] = 4'hF;
    void'(model_write(32'h20, 4'd0, 3'b010, 2'b01, 1));
    axi_read(4'h5, 32'h100, 4'd3, 3'b010, 2'b01, 1);
    check_read_model("stall_rd", 4'h5, 32'h100, 4'd3, 3'b010, 2'b01);
  endtask

  task automatic run_reset_abort();
    int t;
    @(negedge clk);
    arid = 4'hD; araddr = 32'h100; arlen = 4'd7; arsize = 3'b010; arburst = 2'b01; arvalid = 1'b1;
    #1; t = 0;
    while (!arready && t < 50) begin @(negedge clk); #1; t++; end
    chk("abr_arready", 32'(arready), 32'h1);
    @(negedge clk);
    arvalid = 1'b0; rready = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #1;
    chk("abr_rvalid", 32'(rvalid), 32'h0);
    chk("abr_rdata", rdata, 32'h0);
    rst = 1'b0; rready = 1'b0;
    axi_read(4'hE, 32'h104, 4'd0, 3'b010, 2'b01, 0);
    check_read_model("abr_next", 4'hE, 32'h104, 4'd0, 3'b010, 2'b01);

    @(negedge clk);
    awid = 4'hA; awaddr = 32'h600; awlen = 4'd3; awsize = 3'b010; awburst = 2'b01; awvalid = 1'b1;
    #1;
    chk("abw_awready", 32'(awready), 32'h1);
    @(negedge clk);
    awvalid = 1'b0;
    for (int b = 0; b < 2; b++) begin
      wbuf[b] = 32'h6000 + 32'(b); sbuf[b] = 4'hF;
      wvalid = 1'b1; wdata = wbuf[b]; wstrb = 4'hF; wlast = 1'b0;
      @(negedge clk);
    end
    wvalid = 1'b0;
    void'(model_write(32'h600, 4'd3, 3'b010, 2'b01, 2));
    rst = 1'b1;
    @(negedge clk);
    #1;
    chk("abw_ctrl", 32'({bvalid, wready}), 32'h0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("abw_nob", 32'(bvalid), 32'h0);
    axi_read(4'h4, 32'h600, 4'd1, 3'b010, 2'b01, 0);
    check_read_model("abw_rd", 4'h4, 32'h600, 4'd1, 3'b010, 2'b01);
  endtask

  task automatic run_random(input int iters);
    logic [31:0] a; logic [3:0] len, id; logic [2:0] size; logic [1:0] burst, resp, er; logic [3:0] rb;
    int nb;
    for (int it = 0; it < iters; it++) begin
      a     = $urandom;
      len   = 4'($urandom_range(0, 7));
      size  = ($urandom_range(0, 7) == 0) ? 3'b001 : 3'b010;
      burst = 2'($urandom_range(0, 3));
      id    = 4'($urandom_range(0, 15));
      nb    = ($urandom_range(0, 7) == 0) ? $urandom_range(1, int'(len) + 1) : int'(len) + 1;
      for (int b = 0; b < 16; b++) begin
        wbuf[b] = $urandom;
        sbuf[b] = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'hF;
      end
      axi_write(id, a, len, size, burst, nb, $urandom_range(0, 2), resp, rb);
      er = model_write(a, len, size, burst, nb);
      chk("rnd_bresp", 32'(resp), 32'(er));
      chk("rnd_bid", 32'(rb), 32'(id));
      id   = 4'($urandom_range(0, 15));
      size = ($urandom_range(0, 9) == 0) ? 3'b000 : 3'b010;
      axi_read(id, a, len, size, burst, 2);
      check_read_model("rnd_rd", id, a, len, size, burst);
    end
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) known[i] = 1'b0;
    do_reset();
    run_table();
    run_tie_and_stall();
    run_reset_abort();
    run_random(30);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got running, want finished");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/axi_ram_slave.md
AXI_RAM_SLAVE -- requirements
Module: axi_ram_slave

Interface
REQ-001 Parameter ADDR_W, default 12, word-address bits; memory depth 2^ADDR_W 32-bit words.
REQ-002 clk  input  1  sole clock; all state changes on rising edge.
REQ-003 rst  input  1  reset; synchronous, active-high.
REQ-004 arid[3:0] araddr[31:0] arlen[3:0] arsize[2:0] arburst[1:0] arvalid  input  read-address channel from the initiator.
REQ-005 arlock[1:0] arcache[3:0] arprot[2:0]  input  accepted and ignored.
REQ-006 arready  output  1  read-address accept.
REQ-007 rid[3:0] rdata[31:0] rresp[1:0] rlast rvalid  output  read-data channel; rready  input  1  initiator accept.
REQ-008 awid[3:0] awaddr[31:0] awlen[3:0] awsize[2:0] awburst[1:0] awvalid  input  write-address channel.
REQ-009 awlock[1:0] awcache[3:0] awprot[2:0]  input  accepted and ignored.
REQ-010 awready  output  1  write-address accept.
REQ-011 wid[3:0] wdata[31:0] wstrb[3:0] wlast wvalid  input  write-data channel; wid ignored.
REQ-012 wready  output  1  write-data accept.
REQ-013 bid[3:0] bresp[1:0] bvalid  output  write response; bready  input  1  initiator accept.

Function
REQ-014 Single FSM, states IDLE, RD, WR, WRESP; one transaction in flight; internal single-ported array.
REQ-015 IDLE, only arvalid: arready=1 combinationally that cycle; handshake captures arid/araddr/arlen/arsize/arburst; next state RD.
REQ-016 IDLE, only awvalid: awready=1 that cycle; handshake captures awid/awaddr/awlen/awsize/awburst; next state WR.
REQ-017 IDLE, both valid: grant the class not granted last; after reset last-grant=write, so the first tie goes to read; the ungranted ready stays 0.
REQ-018 arready/awready are 0 in every state except IDLE.
REQ-019 Word index = addr[ADDR_W+1:2]; addr[1:0] and upper bits ignored; index wraps modulo 2^ADDR_W.
REQ-020 Burst: arburst/awburst 2'b00 FIXED (index constant); any other value treated as INCR (index +1 per beat).
REQ-021 RD: first rvalid the cycle after the AR handshake; rdata registered from array; beat n+1 valid the cycle after beat n handshake (one beat/cycle when rready held 1).
REQ-022 rvalid, rdata, rid, rresp, rlast stable while rvalid=1 and rready=0.
REQ-023 Exactly arlen+1 beats; rlast=1 only on beat arlen; rid = captured arid; after the last handshake, next state IDLE.
REQ-024 arsize!=3'b010: all arlen+1 beats still returned with rdata=0, rresp=2'b10 (SLVERR); otherwise rresp=2'b00.
REQ-025 WR: wready=1 throughout; each wvalid&wready beat writes byte k of the word when wstrb[k]=1, only if awsize==3'b010.
REQ-026 WR: beat counter from 0; beat with wlast=1 ends the burst, next state WRESP.
REQ-027 bresp=2'b10 if awsize!=3'b010 or wlast beat index != awlen; else 2'b00.
REQ-028 WRESP: bvalid=1, bid = captured awid; bvalid, bid, bresp held until bready; then IDLE.
REQ-029 All array writes of a burst complete before bvalid rises; a read accepted after the B handshake returns the new data.
REQ-030 No combinational path from rready/bready/wvalid to any AXI output other than arready/awready.

Reset
REQ-031 rst=1 on an edge: state IDLE, last-grant=write, beat counters 0; arready, awready, wready, rvalid, rlast, bvalid = 0; rid, bid, rresp, bresp, rdata = 0.
REQ-032 Array contents are not reset.
REQ-033 Reset mid-burst aborts the transaction; no further R/B beats; array words already written keep their values.

Verification
REQ-034 Single write awaddr=0x10, awlen=0, wdata=0xDEADBEEF, wstrb=4'hF, bready=1 -> bvalid one cycle after wlast beat, bresp=00, bid=awid; read araddr=0x10 -> rdata=0xDEADBEEF, rlast=1, rvalid the cycle after AR handshake.
REQ-035 INCR write len=3 at 0x100 with data 1..4, then read len=3, rready=1 -> 4 consecutive beats 1,2,3,4, rlast on 4th only, rid echoes arid=4'h5.
REQ-036 Byte strobe: word 0x11223344 then wstrb=4'b0010, wdata=0x0000AA00 -> readback 0x1122AA44.
REQ-037 arvalid and awvalid raised the same cycle after reset -> arready first; next tie -> awready first; rready toggled 1/0 -> R signals stable while stalled.
REQ-038 arsize=3'b001 len=1 -> 2 beats, rdata=0, rresp=10; write with early wlast (awlen=2, wlast on beat 1) -> bresp=10; rst asserted mid read burst -> rvalid=0 next cycle, FSM accepts new AR.
